c2f_rc_tracker: RTL and testbench

- Parametrised successor of the per-thread remote-access (C2F) tracking logic in the GPC data-memory wrapper.
- Generalises from 4 fixed threads to NUM_THREADS.
- Adds behaviour the current wrapper lacks:
  - honours C2F_ReqStall backpressure;
  - runs a per-thread timeout with error completion;
  - detects unexpected and protocol-violating responses.
- Sits between the core Q103H memory stage and the ring C2F request/response ports; the local D_MEM/CR muxing stays in the wrapper.

---
 rtl/lotr_pkg.sv | 18 +
 rtl/c2f_rc_tracker_if.sv | 58 +++++
 rtl/c2f_thread_slot.sv | 64 ++++++
 rtl/c2f_rc_tracker.sv | 136 +++++++++++++
 tb/tb_c2f_rc_tracker.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lotr_pkg.sv
// Shared types and constants for the LOTR core-to-fabric (C2F) remote-access logic.
package lotr_pkg;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } t_opcode;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    RSP_RDY  = 2'd2
  } t_rc_state;

  localparam int          C2F_TIMEOUT_DEFAULT = 1024;
  localparam logic [31:0] C2F_ERR_DATA        = 32'hDEAD_BEEF;

endpackage

// File: rtl/c2f_rc_tracker_if.sv
// Core Q103H/Q104H and ring C2F request/response signals seen by the remote-access tracker.
interface c2f_rc_tracker_if #(
  parameter int NUM_THREADS = 4,
  parameter int TID_W       = $clog2(NUM_THREADS)
);
  import lotr_pkg::*;

  // Core memory stage
  logic [NUM_THREADS-1:0] ThreadQ103H;
  logic                   RdEnQ103H;
  logic                   WrEnQ103H;
  logic [31:0]            AddressQ103H;
  logic [31:0]            WrDataQ103H;
  logic                   MatchLocalCoreQ103H;
  logic                   C2F_ReqAcceptQ103H;
  logic [NUM_THREADS-1:0] ThreadRcAccess;
  logic                   C2F_RspMatchQ104H;
  logic [31:0]            C2F_RspDataQ104H;
  logic                   RspErrQ104H;

  // Ring request/response
  logic                   C2F_ReqStall;
  logic                   C2F_ReqValidQ500H;
  t_opcode                C2F_ReqOpcodeQ500H;
  logic [TID_W-1:0]       C2F_ReqThreadIDQ500H;
  logic [31:0]            C2F_ReqAddressQ500H;
  logic [31:0]            C2F_ReqDataQ500H;
  logic                   C2F_RspValidQ502H;
  logic [TID_W-1:0]       C2F_RspThreadIDQ502H;
  logic [31:0]            C2F_RspDataQ502H;

  // Status
  logic                   UnexpRspErr;
  logic                   ProtErr;

  // Core/ring environment side
  modport master (
    output ThreadQ103H, RdEnQ103H, WrEnQ103H, AddressQ103H, WrDataQ103H,
    output MatchLocalCoreQ103H, C2F_ReqStall,
    output C2F_RspValidQ502H, C2F_RspThreadIDQ502H, C2F_RspDataQ502H,
    input  C2F_ReqValidQ500H, C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H,
    input  C2F_ReqAddressQ500H, C2F_ReqDataQ500H, C2F_ReqAcceptQ103H,
    input  ThreadRcAccess, C2F_RspMatchQ104H, C2F_RspDataQ104H, RspErrQ104H,
    input  UnexpRspErr, ProtErr
  );

  // Tracker side
  modport slave (
    input  ThreadQ103H, RdEnQ103H, WrEnQ103H, AddressQ103H, WrDataQ103H,
    input  MatchLocalCoreQ103H, C2F_ReqStall,
    input  C2F_RspValidQ502H, C2F_RspThreadIDQ502H, C2F_RspDataQ502H,
    output C2F_ReqValidQ500H, C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H,
    output C2F_ReqAddressQ500H, C2F_ReqDataQ500H, C2F_ReqAcceptQ103H,
    output ThreadRcAccess, C2F_RspMatchQ104H, C2F_RspDataQ104H, RspErrQ104H,
    output UnexpRspErr, ProtErr
  );

endinterface

// File: rtl/c2f_thread_slot.sv
// One hardware thread's remote-read tracker: IDLE/WAIT_RSP/RSP_RDY FSM, timeout counter,
// and the captured read data and error flag handed back at the thread's next slot.
module c2f_thread_slot
  import lotr_pkg::*;
#(
  parameter int          TIMEOUT_CYC = C2F_TIMEOUT_DEFAULT,
  parameter int          TO_CNT_W    = 11,
  parameter logic [31:0] ERR_DATA    = C2F_ERR_DATA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rsp_hit,
  input  logic [31:0] rsp_data,
  input  logic        consume,
  output t_rc_state   state,
  output logic [31:0] data,
  output logic        err
);

  localparam bit                  TIMEOUT_EN = (TIMEOUT_CYC != 0);
  localparam logic [TO_CNT_W-1:0] TO_LAST    = TO_CNT_W'(TIMEOUT_CYC - 1);

  logic [TO_CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every slot and the top
  // level see pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      data  <= '0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= WAIT_RSP;
            cnt   <= '0;
          end
        end
        WAIT_RSP: begin
          // A response landing on the timeout cycle wins over the timeout.
          if (rsp_hit) begin
            state <= RSP_RDY;
            data  <= rsp_data;
            err   <= 1'b0;
          end else if (TIMEOUT_EN && cnt == TO_LAST) begin
            state <= RSP_RDY;
            data  <= ERR_DATA;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + TO_CNT_W'(1);
          end
        end
        RSP_RDY: begin
          if (consume) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/c2f_rc_tracker.sv
// Per-thread remote-access tracker between the core Q103H memory stage and the ring C2F ports:
// request qualification/encode, response decode, Q104H return path and sticky protocol errors.
module c2f_rc_tracker
  import lotr_pkg::*;
#(
  parameter int          NUM_THREADS = 4,
  parameter int          TID_W       = $clog2(NUM_THREADS),
  parameter int          TIMEOUT_CYC = C2F_TIMEOUT_DEFAULT,
  parameter int          TO_CNT_W    = 11,
  parameter logic [31:0] ERR_DATA    = C2F_ERR_DATA
) (
  input logic             QClk,
  input logic             RstQnnnL,
  c2f_rc_tracker_if.slave bus
);

  t_rc_state              slot_state [NUM_THREADS];
  logic [31:0]            slot_data  [NUM_THREADS];
  logic [NUM_THREADS-1:0] slot_err;

  logic [NUM_THREADS-1:0] idle_vec;
  logic [NUM_THREADS-1:0] wait_vec;
  logic [NUM_THREADS-1:0] rdy_vec;
  logic [NUM_THREADS-1:0] start_vec;
  logic [NUM_THREADS-1:0] hit_vec;
  logic [NUM_THREADS-1:0] consume_vec;

  logic             access;
  logic             thread_onehot;
  logic             sel_idle;
  logic             remote;
  logic             accept;
  logic             prot_viol;
  logic             unexp;
  logic [TID_W-1:0] tid_enc;
  logic [31:0]      sel_data;
  logic             sel_err;

  // ---------------- Request path (Q103H, combinational) ----------------
  assign access        = bus.RdEnQ103H | bus.WrEnQ103H;
  assign thread_onehot = $onehot(bus.ThreadQ103H);
  assign sel_idle      = ~|(bus.ThreadQ103H & ~idle_vec);
  assign remote        = access & ~bus.MatchLocalCoreQ103H & thread_onehot & sel_idle;
  assign accept        = remote & ~bus.C2F_ReqStall;

  // Writes are posted; only an accepted read opens a transaction.
  assign start_vec = (accept & ~bus.WrEnQ103H) ? bus.ThreadQ103H : '0;

  // A frozen thread issuing a ring access, or a malformed thread vector, is a core bug.
  assign prot_viol = access &
                     (~thread_onehot | (~bus.MatchLocalCoreQ103H & ~sel_idle));

  // NOTE: every variable written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    tid_enc = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (bus.ThreadQ103H[t]) tid_enc = TID_W'(t);
    end
  end

  assign bus.C2F_ReqValidQ500H    = remote;
  assign bus.C2F_ReqAcceptQ103H   = accept;
  assign bus.C2F_ReqOpcodeQ500H   = bus.WrEnQ103H ? OP_WR : OP_RD;
  assign bus.C2F_ReqThreadIDQ500H = tid_enc;
  assign bus.C2F_ReqAddressQ500H  = remote ? bus.AddressQ103H : '0;
  assign bus.C2F_ReqDataQ500H     = bus.WrDataQ103H;

  // ---------------- Response decode (Q502H) ----------------
  // TIDs at or above NUM_THREADS match no slot and so fall out as unexpected.
  always_comb begin
    hit_vec = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      hit_vec[t] = bus.C2F_RspValidQ502H && (bus.C2F_RspThreadIDQ502H == TID_W'(t));
    end
  end

  assign unexp = bus.C2F_RspValidQ502H & ~|(hit_vec & wait_vec);

  // ---------------- Per-thread slots ----------------
  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_slot
    c2f_thread_slot #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .TO_CNT_W    (TO_CNT_W),
      .ERR_DATA    (ERR_DATA)
    ) u_slot (
      .clk      (QClk),
      .rst_n    (RstQnnnL),
      .start    (start_vec[t]),
      .rsp_hit  (hit_vec[t]),
      .rsp_data (bus.C2F_RspDataQ502H),
      .consume  (consume_vec[t]),
      .state    (slot_state[t]),
      .data     (slot_data[t]),
      .err      (slot_err[t])
    );

    assign idle_vec[t] = (slot_state[t] == IDLE);
    assign wait_vec[t] = (slot_state[t] == WAIT_RSP);
    assign rdy_vec[t]  = (slot_state[t] == RSP_RDY);
  end

  assign bus.ThreadRcAccess = ~idle_vec;

  // A ready thread hands its result back on its own Q103H slot.
  assign consume_vec = rdy_vec & bus.ThreadQ103H;

  always_comb begin
    sel_data = '0;
    sel_err  = 1'b0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (consume_vec[t]) begin
        sel_data = slot_data[t];
        sel_err  = slot_err[t];
      end
    end
  end

  // ---------------- Q104H return path and sticky errors ----------------
  always_ff @(posedge QClk) begin
    if (!RstQnnnL) begin
      bus.C2F_RspMatchQ104H <= 1'b0;
      bus.C2F_RspDataQ104H  <= '0;
      bus.RspErrQ104H       <= 1'b0;
      bus.UnexpRspErr       <= 1'b0;
      bus.ProtErr           <= 1'b0;
    end else begin
      bus.C2F_RspMatchQ104H <= |consume_vec;
      bus.C2F_RspDataQ104H  <= sel_data;
      bus.RspErrQ104H       <= sel_err;
      if (unexp)     bus.UnexpRspErr <= 1'b1;
      if (prot_viol) bus.ProtErr     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_c2f_rc_tracker.sv
// Directed bench for c2f_rc_tracker: per-cycle comparison against a transaction-level model
// plus literal expectations for the headline scenarios.
module tb_c2f_rc_tracker;
  import lotr_pkg::*;

  localparam int NT      = 4;
  localparam int TO      = 16;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic QClk;
  logic RstQnnnL;

  c2f_rc_tracker_if #(.NUM_THREADS(NT), .TID_W(2)) bus ();

  c2f_rc_tracker #(
    .NUM_THREADS (NT),
    .TID_W       (2),
    .TIMEOUT_CYC (TO),
    .TO_CNT_W    (11),
    .ERR_DATA    (ERRD)
  ) dut (
    .QClk     (QClk),
    .RstQnnnL (RstQnnnL),
    .bus      (bus)
  );

  initial QClk = 1'b0;
  always #5 QClk = ~QClk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Transaction-level model ----------------
  // A thread is busy from its accepted read until its result is handed back; it is
  // resolved once a response or its deadline (accept edge + TO) has been seen.
  bit          m_busy  [NT];
  bit          m_ready [NT];
  int          m_deadline [NT];
  logic [31:0] m_data  [NT];
  bit          m_err   [NT];
  bit          e_match, e_err, e_unexp, e_prot;
  logic [31:0] e_data;
  int          edge_no = 0;

  always @(negedge QClk) begin : model
    int         idx;
    int         tid;
    bit         onehot, rw, e_valid, e_accept;
    logic [3:0] busy_vec;

    onehot = ($countones(bus.ThreadQ103H) == 1);
    idx = 0;
    for (int t = 0; t < NT; t++) if (bus.ThreadQ103H[t]) idx = t;
    for (int t = 0; t < NT; t++) busy_vec[t] = m_busy[t];
    rw       = bus.RdEnQ103H | bus.WrEnQ103H;
    e_valid  = rw && !bus.MatchLocalCoreQ103H && onehot && !busy_vec[idx];
    e_accept = e_valid && !bus.C2F_ReqStall;

    check("m_req_valid", 32'(bus.C2F_ReqValidQ500H), 32'(e_valid));
    check("m_req_accept", 32'(bus.C2F_ReqAcceptQ103H), 32'(e_accept));
    check("m_rc_access", 32'(bus.ThreadRcAccess), 32'(busy_vec));
    check("m_rsp_match", 32'(bus.C2F_RspMatchQ104H), 32'(e_match));
    check("m_rsp_err", 32'(bus.RspErrQ104H), 32'(e_err));
    check("m_unexp", 32'(bus.UnexpRspErr), 32'(e_unexp));
    check("m_prot", 32'(bus.ProtErr), 32'(e_prot));
    if (e_valid) begin
      check("m_req_op", 32'(bus.C2F_ReqOpcodeQ500H), bus.WrEnQ103H ? 32'd1 : 32'd0);
      check("m_req_tid", 32'(bus.C2F_ReqThreadIDQ500H), 32'(idx));
      check("m_req_addr", bus.C2F_ReqAddressQ500H, bus.AddressQ103H);
    end else begin
      check("m_req_addr0", bus.C2F_ReqAddressQ500H, 32'h0);
    end
    if (e_match) check("m_rsp_data", bus.C2F_RspDataQ104H, e_data);

    // Effect of the coming clock edge
    if (!RstQnnnL) begin
      for (int t = 0; t < NT; t++) begin
        m_busy[t] = 0; m_ready[t] = 0; m_err[t] = 0; m_data[t] = '0;
      end
      e_match = 0; e_err = 0; e_data = '0; e_unexp = 0; e_prot = 0;
    end else begin
      e_match = 0; e_err = 0; e_data = '0;
      for (int t = 0; t < NT; t++) begin
        if (m_busy[t] && m_ready[t] && bus.ThreadQ103H[t]) begin
          e_match = 1; e_data = m_data[t]; e_err = m_err[t];
          m_busy[t] = 0; m_ready[t] = 0;
        end
      end
      if (bus.C2F_RspValidQ502H) begin
        tid = int'(bus.C2F_RspThreadIDQ502H);
        if (tid < NT && m_busy[tid] && !m_ready[tid]) begin
          m_ready[tid] = 1; m_data[tid] = bus.C2F_RspDataQ502H; m_err[tid] = 0;
        end else begin
          e_unexp = 1;
        end
      end
      for (int t = 0; t < NT; t++) begin
        if (m_busy[t] && !m_ready[t] && edge_no == m_deadline[t]) begin
          m_ready[t] = 1; m_data[t] = ERRD; m_err[t] = 1;
        end
      end
      if (e_accept && !bus.WrEnQ103H) begin
        m_busy[idx] = 1; m_ready[idx] = 0; m_deadline[idx] = edge_no + TO;
      end
      if (rw && (!onehot || (!bus.MatchLocalCoreQ103H && busy_vec[idx]))) e_prot = 1;
    end
    edge_no++;
  end

  // ---------------- Directed stimulus ----------------
  task automatic tick();
    @(posedge QClk);
    #1;
  endtask

  task automatic idle_in();
    bus.ThreadQ103H          = '0;
    bus.RdEnQ103H            = 1'b0;
    bus.WrEnQ103H            = 1'b0;
    bus.AddressQ103H         = '0;
    bus.WrDataQ103H          = '0;
    bus.MatchLocalCoreQ103H  = 1'b0;
    bus.C2F_ReqStall         = 1'b0;
    bus.C2F_RspValidQ502H    = 1'b0;
    bus.C2F_RspThreadIDQ502H = '0;
    bus.C2F_RspDataQ502H     = '0;
  endtask

  task automatic rd(input logic [3:0] thr, input logic [31:0] addr);
    bus.ThreadQ103H  = thr;
    bus.RdEnQ103H    = 1'b1;
    bus.AddressQ103H = addr;
  endtask

  task automatic rsp(input logic [1:0] tid, input logic [31:0] data);
    bus.C2F_RspValidQ502H    = 1'b1;
    bus.C2F_RspThreadIDQ502H = tid;
    bus.C2F_RspDataQ502H     = data;
  endtask

  initial begin
    RstQnnnL = 1'b0;
    idle_in();
    tick(); tick();
    RstQnnnL = 1'b1;
    @(negedge QClk);
    check("rst_access", 32'(bus.ThreadRcAccess), 32'h0);
    check("rst_match", 32'(bus.C2F_RspMatchQ104H), 32'h0);
    check("rst_unexp", 32'(bus.UnexpRspErr), 32'h0);
    check("rst_prot", 32'(bus.ProtErr), 32'h0);

    // Remote read, thread 1, response 5 cycles after accept
    tick();
    rd(4'b0010, 32'h0300_0400);
    @(negedge QClk);
    check("t1_valid", 32'(bus.C2F_ReqValidQ500H), 32'h1);
    check("t1_op", 32'(bus.C2F_ReqOpcodeQ500H), 32'(OP_RD));
    check("t1_tid", 32'(bus.C2F_ReqThreadIDQ500H), 32'h1);
    check("t1_accept", 32'(bus.C2F_ReqAcceptQ103H), 32'h1);
    tick(); idle_in();
    @(negedge QClk);
    check("t1_access", 32'(bus.ThreadRcAccess), 32'b0010);
    repeat (4) tick();
    rsp(2'd1, 32'h1234_5678);
    tick(); idle_in();
    @(negedge QClk);
    check("t1_access_rdy", 32'(bus.ThreadRcAccess), 32'b0010);
    tick(); tick();
    bus.ThreadQ103H = 4'b0010;
    tick(); idle_in();
    @(negedge QClk);
    check("t1_match", 32'(bus.C2F_RspMatchQ104H), 32'h1);
    check("t1_data", bus.C2F_RspDataQ104H, 32'h1234_5678);
    check("t1_err", 32'(bus.RspErrQ104H), 32'h0);
    check("t1_access_done", 32'(bus.ThreadRcAccess), 32'h0);
    tick();
    @(negedge QClk);
    check("t1_match_pulse", 32'(bus.C2F_RspMatchQ104H), 32'h0);

    // Posted write, thread 2
    bus.ThreadQ103H  = 4'b0100;
    bus.WrEnQ103H    = 1'b1;
    bus.AddressQ103H = 32'h0400_0010;
    bus.WrDataQ103H  = 32'hCAFE_F00D;
    @(negedge QClk);
    check("wr_op", 32'(bus.C2F_ReqOpcodeQ500H), 32'(OP_WR));
    check("wr_data", bus.C2F_ReqDataQ500H, 32'hCAFE_F00D);
    check("wr_accept", 32'(bus.C2F_ReqAcceptQ103H), 32'h1);
    tick(); idle_in();
    @(negedge QClk);
    check("wr_posted", 32'(bus.ThreadRcAccess), 32'h0);

    // Local access never reaches the ring
    rd(4'b0001, 32'h0000_0040);
    bus.MatchLocalCoreQ103H = 1'b1;
    @(negedge QClk);
    check("local_valid", 32'(bus.C2F_ReqValidQ500H), 32'h0);
    tick(); idle_in();

    // Stall for 3 cycles, then accept; thread 0 then times out
    rd(4'b0001, 32'h0500_0000);
    bus.C2F_ReqStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge QClk);
      check("stall_valid", 32'(bus.C2F_ReqValidQ500H), 32'h1);
      check("stall_accept", 32'(bus.C2F_ReqAcceptQ103H), 32'h0);
      check("stall_idle", 32'(bus.ThreadRcAccess), 32'h0);
      tick();
    end
    bus.C2F_ReqStall = 1'b0;
    @(negedge QClk);
    check("unstall_accept", 32'(bus.C2F_ReqAcceptQ103H), 32'h1);
    tick(); idle_in();
    @(negedge QClk);
    check("unstall_access", 32'(bus.ThreadRcAccess), 32'b0001);
    repeat (15) tick();
    bus.ThreadQ103H = 4'b0001;
    tick();
    @(negedge QClk);
    check("to_not_yet", 32'(bus.C2F_RspMatchQ104H), 32'h0);
    tick(); idle_in();
    @(negedge QClk);
    check("to_match", 32'(bus.C2F_RspMatchQ104H), 32'h1);
    check("to_data", bus.C2F_RspDataQ104H, 32'hDEAD_BEEF);
    check("to_err", 32'(bus.RspErrQ104H), 32'h1);

    // Out-of-order responses for threads 0, 2, 3
    tick();
    rd(4'b0001, 32'h0600_0000); tick();
    rd(4'b0100, 32'h0600_0004); tick();
    rd(4'b1000, 32'h0600_0008); tick();
    idle_in();
    @(negedge QClk);
    check("ooo_access", 32'(bus.ThreadRcAccess), 32'b1101);
    rsp(2'd3, 32'h0000_000A); tick();
    rsp(2'd0, 32'h0000_000B); tick();
    rsp(2'd2, 32'h0000_000C); tick();
    idle_in();
    bus.ThreadQ103H = 4'b0001; tick();
    bus.ThreadQ103H = 4'b0100;
    @(negedge QClk);
    check("ooo_t0", bus.C2F_RspDataQ104H, 32'h0000_000B);
    tick();
    bus.ThreadQ103H = 4'b1000;
    @(negedge QClk);
    check("ooo_t2", bus.C2F_RspDataQ104H, 32'h0000_000C);
    tick(); idle_in();
    @(negedge QClk);
    check("ooo_t3", bus.C2F_RspDataQ104H, 32'h0000_000A);
    check("ooo_unexp", 32'(bus.UnexpRspErr), 32'h0);

    // Unexpected response for idle thread 2
    rsp(2'd2, 32'h0000_0077);
    tick(); idle_in();
    @(negedge QClk);
    check("unexp_set", 32'(bus.UnexpRspErr), 32'h1);

    // Response on the timeout cycle wins
    rd(4'b0010, 32'h0700_0000);
    tick(); idle_in();
    repeat (15) tick();
    rsp(2'd1, 32'h5555_AAAA);
    tick(); idle_in();
    bus.ThreadQ103H = 4'b0010;
    tick(); idle_in();
    @(negedge QClk);
    check("race_match", 32'(bus.C2F_RspMatchQ104H), 32'h1);
    check("race_data", bus.C2F_RspDataQ104H, 32'h5555_AAAA);
    check("race_err", 32'(bus.RspErrQ104H), 32'h0);
    check("unexp_sticky", 32'(bus.UnexpRspErr), 32'h1);

    // Request from a busy thread
    rd(4'b1000, 32'h0800_0000);
    tick();
    @(negedge QClk);
    check("busy_valid", 32'(bus.C2F_ReqValidQ500H), 32'h0);
    check("busy_accept", 32'(bus.C2F_ReqAcceptQ103H), 32'h0);
    tick(); idle_in();
    @(negedge QClk);
    check("prot_set", 32'(bus.ProtErr), 32'h1);

    // Reset with thread 1 in WAIT_RSP, then a stale response
    rd(4'b0010, 32'h0900_0000);
    tick(); idle_in();
    @(negedge QClk);
    check("pre_rst_access", 32'(bus.ThreadRcAccess), 32'b1010);
    RstQnnnL = 1'b0;
    tick();
    RstQnnnL = 1'b1;
    @(negedge QClk);
    check("post_rst_access", 32'(bus.ThreadRcAccess), 32'h0);
    check("post_rst_prot", 32'(bus.ProtErr), 32'h0);
    check("post_rst_unexp", 32'(bus.UnexpRspErr), 32'h0);
    rsp(2'd1, 32'h0000_0099);
    tick(); idle_in();
    @(negedge QClk);
    check("stale_unexp", 32'(bus.UnexpRspErr), 32'h1);
    bus.ThreadQ103H = 4'b0010;
    tick(); idle_in();
    @(negedge QClk);
    check("stale_no_match", 32'(bus.C2F_RspMatchQ104H), 32'h0);

    // Thread vector not one-hot
    rd(4'b0011, 32'h0A00_0000);
    @(negedge QClk);
    check("multi_valid", 32'(bus.C2F_ReqValidQ500H), 32'h0);
    tick(); idle_in();
    @(negedge QClk);
    check("multi_prot", 32'(bus.ProtErr), 32'h1);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
